// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial add/subtract unit, DIGIT bits per clock, valid/ready on both sides
// Subtraction runs as a + ~b + 1 with the +1 entering as the initial carry.
module serial_adder #(
  parameter int WIDTH  = 8,
  parameter int DIGIT  = 1,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = DIGIT + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc_sh;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] b_eff;
  logic [DW-1:0]    dsum;
  logic [CW-1:0]    cnt;
  logic             c_q;
  logic             c_nx;
  logic             sub_q;
  logic             a_msb;
  logic             b_msb;
  logic             last;
  logic             ovf_nx;

  assign b_eff = sub ? ~b : b;
  assign last  = (cnt == CW'(N - 1));

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = BUSY;
      end
      BUSY: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // One digit per cycle; the digit sum enters at the MSB end so the result is aligned after N shifts.
  always_comb begin
    dsum   = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + DW'(c_q);
    c_nx   = dsum[DIGIT];
    acc_nx = (acc_sh >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    ovf_nx = SIGNED ? ((a_msb == b_msb) && (acc_nx[WIDTH-1] != a_msb))
                    : (sub_q ? ~c_nx : c_nx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      acc_sh   <= '0;
      cnt      <= '0;
      c_q      <= 1'b0;
      sub_q    <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b_eff;
            c_q   <= sub;
            sub_q <= sub;
            a_msb <= a[WIDTH-1];
            b_msb <= b_eff[WIDTH-1];
            cnt   <= '0;
          end
        end
        BUSY: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          acc_sh <= acc_nx;
          c_q    <= c_nx;
          cnt    <= cnt + CW'(1);
          // Outputs only change on the edge that enters DONE, so they hold through backpressure.
          if (last) begin
            result   <= acc_nx;
            carry    <= c_nx;
            overflow <= ovf_nx;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized bench for serial_adder against a transaction-level arithmetic model
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       in_valid1 = 1'b0, sub1 = 1'b0, out_ready1 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0;
  logic       in_valid4 = 1'b0, sub4 = 1'b0, out_ready4 = 1'b0;
  logic [7:0] a4 = '0, b4 = '0;

  logic       s0_in_ready, s0_out_valid, s0_carry, s0_overflow;
  logic [7:0] s0_result;
  logic       s1_in_ready, s1_out_valid, s1_carry, s1_overflow;
  logic [7:0] s1_result;
  logic       d4_in_ready, d4_out_valid, d4_carry, d4_overflow;
  logic [7:0] d4_result;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1), .SIGNED(1'b0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(s0_in_ready),
    .a(a1), .b(b1), .sub(sub1), .out_valid(s0_out_valid), .out_ready(out_ready1),
    .result(s0_result), .carry(s0_carry), .overflow(s0_overflow)
  );

  serial_adder #(.WIDTH(8), .DIGIT(1), .SIGNED(1'b1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(s1_in_ready),
    .a(a1), .b(b1), .sub(sub1), .out_valid(s1_out_valid), .out_ready(out_ready1),
    .result(s1_result), .carry(s1_carry), .overflow(s1_overflow)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4), .SIGNED(1'b1)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(d4_in_ready),
    .a(a4), .b(b4), .sub(sub4), .out_valid(d4_out_valid), .out_ready(out_ready4),
    .result(d4_result), .carry(d4_carry), .overflow(d4_overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {result, carry, overflow} from integer arithmetic on the operand values.
  function automatic logic [9:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                        input logic s, input bit sgn);
    int ua, ub, r, sa, sb, sr;
    logic [7:0] res;
    logic c, ov;
    ua  = int'(a);
    ub  = int'(b);
    r   = s ? ua - ub : ua + ub;
    res = r[7:0];
    c   = s ? (ua >= ub) : (r > 255);
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    sr  = s ? sa - sb : sa + sb;
    ov  = sgn ? ((sr > 127) || (sr < -128)) : (s ? (ua < ub) : (r > 255));
    return {res, c, ov};
  endfunction

  int         cyc = 0, acc1 = 0, acc4 = 0;
  bit         pend1 = 0, pend4 = 0, ev1, ev4;
  logic [9:0] m;
  logic [7:0] e1_res, e4_res;
  logic       e1_c, e1_ovu, e1_ovs, e4_c, e4_ov;

  // Transaction model: an accepted op yields its result exactly N cycles later and holds until taken.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pend1 = 0;
      pend4 = 0;
      chk("rst_s0", {s0_in_ready, s0_out_valid, s0_result, s0_carry, s0_overflow}, 12'h800);
      chk("rst_s1", {s1_in_ready, s1_out_valid, s1_result, s1_carry, s1_overflow}, 12'h800);
      chk("rst_d4", {d4_in_ready, d4_out_valid, d4_result, d4_carry, d4_overflow}, 12'h800);
    end else begin
      ev1 = pend1 && (cyc >= acc1 + 9);
      ev4 = pend4 && (cyc >= acc4 + 3);
      chk("s0_in_ready", s0_in_ready, !pend1);
      chk("s0_out_valid", s0_out_valid, ev1);
      chk("s1_in_ready", s1_in_ready, !pend1);
      chk("s1_out_valid", s1_out_valid, ev1);
      chk("d4_in_ready", d4_in_ready, !pend4);
      chk("d4_out_valid", d4_out_valid, ev4);
      if (ev1) begin
        chk("s0_result", s0_result, e1_res);
        chk("s0_carry", s0_carry, e1_c);
        chk("s0_overflow", s0_overflow, e1_ovu);
        chk("s1_result", s1_result, e1_res);
        chk("s1_carry", s1_carry, e1_c);
        chk("s1_overflow", s1_overflow, e1_ovs);
      end
      if (ev4) begin
        chk("d4_result", d4_result, e4_res);
        chk("d4_carry", d4_carry, e4_c);
        chk("d4_overflow", d4_overflow, e4_ov);
      end
      if (in_valid1 && !pend1) begin
        pend1 = 1;
        acc1  = cyc;
        m = ref_op(a1, b1, sub1, 1'b0);
        e1_res = m[9:2]; e1_c = m[1]; e1_ovu = m[0];
        m = ref_op(a1, b1, sub1, 1'b1);
        e1_ovs = m[0];
      end else if (ev1 && out_ready1) begin
        pend1 = 0;
      end
      if (in_valid4 && !pend4) begin
        pend4 = 1;
        acc4  = cyc;
        m = ref_op(a4, b4, sub4, 1'b1);
        e4_res = m[9:2]; e4_c = m[1]; e4_ov = m[0];
      end else if (ev4 && out_ready4) begin
        pend4 = 0;
      end
    end
  end

  task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input int hold, output logic [7:0] seen);
    int t;
    a1 = a; b1 = b; sub1 = s; in_valid1 = 1'b1; out_ready1 = 1'b0;
    t = 0;
    while (!s0_in_ready && t < 20) begin @(posedge clk); #1; t++; end
    chk("d1_accept_ready", s0_in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom); sub1 = 1'($urandom);
    t = 0;
    while (!s0_out_valid && t < 40) begin @(posedge clk); #1; t++; end
    chk("d1_latency", t, 8);
    seen = s0_result;
    repeat (hold) begin
      in_valid1 = 1'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid1 = 1'b0; out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    chk("d1_post_hs_in_ready", s0_in_ready, 1'b1);
    chk("d1_post_hs_out_valid", s0_out_valid, 1'b0);
  endtask

  task automatic stream4(input int n);
    int t;
    in_valid4 = 1'b1; out_ready4 = 1'b1; a4 = 8'hFF; b4 = 8'h01; sub4 = 1'b0;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!d4_in_ready && t < 20) begin @(posedge clk); #1; t++; end
      chk("d4_accept_ready", d4_in_ready, 1'b1);
      if (i > 0) chk("d4_period", t + 1, 4);
      @(posedge clk); #1;
      a4 = 8'($urandom); b4 = 8'($urandom); sub4 = 1'($urandom);
    end
    in_valid4 = 1'b0;
    repeat (4) @(posedge clk);
    #1 out_ready4 = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [7:0] seen;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("model_200p100", ref_op(8'd200, 8'd100, 1'b0, 1'b0), {8'd44, 1'b1, 1'b1});
    chk("model_5m7_u", ref_op(8'd5, 8'd7, 1'b1, 1'b0), {8'hFE, 1'b0, 1'b1});
    chk("model_5m7_s", ref_op(8'd5, 8'd7, 1'b1, 1'b1), {8'hFE, 1'b0, 1'b0});
    chk("model_100p50_s", ref_op(8'd100, 8'd50, 1'b0, 1'b1), {8'h96, 1'b0, 1'b1});
    chk("model_80m1_s", ref_op(8'h80, 8'h01, 1'b1, 1'b1), {8'h7F, 1'b1, 1'b1});
    chk("model_ffp1_s", ref_op(8'hFF, 8'h01, 1'b0, 1'b1), {8'h00, 1'b1, 1'b0});

    run1(8'd200, 8'd100, 1'b0, 2, seen);
    chk("t1_result", seen, 8'd44);
    run1(8'd5, 8'd7, 1'b1, 0, seen);
    chk("t2_result", seen, 8'hFE);
    run1(8'd100, 8'd50, 1'b0, 1, seen);
    run1(8'h80, 8'h01, 1'b1, 0, seen);
    run1(8'hFF, 8'h01, 1'b0, 0, seen);
    run1(8'h3C, 8'h11, 1'b1, 5, seen);

    a1 = 8'h55; b1 = 8'h2A; sub1 = 1'b0; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", s0_in_ready, 1'b1);
    chk("abort_out_valid", s0_out_valid, 1'b0);
    chk("abort_result", s0_result, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run1(8'd9, 8'd3, 1'b0, 0, seen);
    chk("abort_next_result", seen, 8'd12);

    for (int i = 0; i < 40; i++) begin
      t = $urandom_range(0, 3);
      run1(8'($urandom), 8'($urandom), 1'($urandom), t, seen);
    end

    stream4(20);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
